// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: clears the register file after reset, then shares its write port
// and read port 1 between core writeback and a debug req/ack channel.
module regfile_port_ctrl #(
  parameter int DBITS = 32,
  parameter int ABITS = 4,
  parameter int WORDS = 1 << ABITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_wr_en,
  input  logic [ABITS-1:0] core_wr_idx,
  input  logic [DBITS-1:0] core_wr_data,
  input  logic [ABITS-1:0] core_rd_idx1,
  output logic             core_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [ABITS-1:0] dbg_idx,
  input  logic [DBITS-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [DBITS-1:0] dbg_rdata,
  output logic             init_done,
  output logic             rf_wrtEn,
  output logic [ABITS-1:0] rf_wrtInd,
  output logic [DBITS-1:0] rf_dIn,
  output logic [ABITS-1:0] rf_rdInd1,
  input  logic [DBITS-1:0] rf_dOut1
);
  typedef enum logic [2:0] {INIT, IDLE, DBG_WR, DBG_RD, WAIT_REL} state_t;
  state_t state;
  logic [ABITS-1:0] cnt, lidx;
  logic [DBITS-1:0] ldata;
  assign core_stall = state == INIT || state == DBG_WR || state == DBG_RD;
  // Core writeback passes straight through whenever the controller does not own the port.
  always_comb begin
    rf_wrtEn  = rst_n && (state == INIT || state == DBG_WR || (!core_stall && core_wr_en));
    rf_wrtInd = state == INIT ? cnt : state == DBG_WR ? lidx : core_wr_idx;
    rf_dIn    = state == INIT ? '0 : state == DBG_WR ? ldata : core_wr_data;
    rf_rdInd1 = state == DBG_RD ? lidx : core_rd_idx1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == ABITS'(WORDS - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: if (dbg_req && !core_wr_en) begin
          lidx  <= dbg_idx;
          ldata <= dbg_wdata;
          state <= dbg_we ? DBG_WR : DBG_RD;
        end
        DBG_WR: begin
          dbg_ack <= 1'b1;
          state   <= WAIT_REL;
        end
        DBG_RD: begin
          dbg_ack   <= 1'b1;
          dbg_rdata <= rf_dOut1;
          state     <= WAIT_REL;
        end
        WAIT_REL: if (!dbg_req) state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: directed checks of init sweep, core pass-through and debug access.
module tb_regfile_port_ctrl;
  logic clk = 0, rst_n = 0;
  logic core_wr_en = 0, dbg_req = 0, dbg_we = 0, fill = 1;
  logic [3:0] core_wr_idx = 0, core_rd_idx1 = 0, dbg_idx = 0;
  logic [31:0] core_wr_data = 0, dbg_wdata = 0;
  logic core_stall, dbg_ack, init_done, rf_wrtEn;
  logic [31:0] dbg_rdata, rf_dIn, rf_dOut1;
  logic [3:0] rf_wrtInd, rf_rdInd1;
  logic [31:0] mem [16];
  int checks = 0, failures = 0, acks;
  regfile_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .core_wr_en(core_wr_en), .core_wr_idx(core_wr_idx),
    .core_wr_data(core_wr_data), .core_rd_idx1(core_rd_idx1), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_idx(dbg_idx), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_done(init_done), .rf_wrtEn(rf_wrtEn),
    .rf_wrtInd(rf_wrtInd), .rf_dIn(rf_dIn), .rf_rdInd1(rf_rdInd1), .rf_dOut1(rf_dOut1)
  );
  always #5 clk = ~clk;
  // External register file: seeded with junk so the sweep's clearing is visible.
  always @(posedge clk)
    if (fill) for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
    else if (rf_wrtEn) mem[rf_wrtInd] <= rf_dIn;
  assign rf_dOut1 = mem[rf_rdInd1];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) step();
    fill = 0;
    #1;
    chk("rst_wren", rf_wrtEn, 0);
    chk("rst_stall", core_stall, 1);
    chk("rst_done", init_done, 0);
    chk("rst_ack", dbg_ack, 0);
    chk("rst_rdata", dbg_rdata, 0);
    step();
    rst_n = 1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("init_wren", rf_wrtEn, 1);
      chk("init_idx", rf_wrtInd, i);
      chk("init_data", rf_dIn, 0);
      chk("init_stall", core_stall, 1);
      chk("init_done_lo", init_done, 0);
      step();
    end
    chk("init_done", init_done, 1);
    chk("idle_stall", core_stall, 0);
    chk("idle_wren", rf_wrtEn, 0);
    chk("cleared7", mem[7], 0);
    chk("cleared15", mem[15], 0);
    // core writeback pass-through
    core_wr_en = 1; core_wr_idx = 3; core_wr_data = 32'hDEADBEEF; core_rd_idx1 = 3;
    #1;
    chk("core_wren", rf_wrtEn, 1);
    chk("core_idx", rf_wrtInd, 3);
    chk("core_data", rf_dIn, 32'hDEADBEEF);
    chk("core_rdidx", rf_rdInd1, 3);
    step();
    core_wr_en = 0;
    chk("core_mem", mem[3], 32'hDEADBEEF);
    // debug write
    dbg_req = 1; dbg_we = 1; dbg_idx = 5; dbg_wdata = 32'h1234;
    #1;
    chk("dw_acc_stall", core_stall, 0);
    step();
    core_wr_en = 1; core_wr_idx = 9; core_wr_data = 32'h9999;
    #1;
    chk("dw_stall", core_stall, 1);
    chk("dw_wren", rf_wrtEn, 1);
    chk("dw_idx", rf_wrtInd, 5);
    chk("dw_data", rf_dIn, 32'h1234);
    chk("dw_ack_lo", dbg_ack, 0);
    step();
    core_wr_en = 0;
    chk("dw_ack", dbg_ack, 1);
    chk("dw_rel_stall", core_stall, 0);
    dbg_req = 0;
    step();
    chk("dw_ack_pulse", dbg_ack, 0);
    chk("dw_mem5", mem[5], 32'h1234);
    chk("dw_mem9", mem[9], 0);
    // debug read
    dbg_req = 1; dbg_we = 0; dbg_idx = 5; core_rd_idx1 = 2;
    #1;
    chk("dr_idle_rdidx", rf_rdInd1, 2);
    step();
    chk("dr_rdidx", rf_rdInd1, 5);
    chk("dr_stall", core_stall, 1);
    chk("dr_wren", rf_wrtEn, 0);
    step();
    chk("dr_ack", dbg_ack, 1);
    chk("dr_rdata", dbg_rdata, 32'h1234);
    chk("dr_rel_rdidx", rf_rdInd1, 2);
    repeat (2) begin
      step();
      chk("dr_held_ack", dbg_ack, 0);
      chk("dr_held_stall", core_stall, 0);
    end
    dbg_req = 0;
    step();
    chk("dr_rdata_hold", dbg_rdata, 32'h1234);
    // core writes win over a pending debug request
    dbg_req = 1; dbg_we = 1; dbg_idx = 7; dbg_wdata = 32'h77;
    for (int k = 0; k < 3; k++) begin
      core_wr_en = 1; core_wr_idx = 4'(10 + k); core_wr_data = 32'h100 + k;
      #1;
      chk("pri_wren", rf_wrtEn, 1);
      chk("pri_idx", rf_wrtInd, 10 + k);
      chk("pri_stall", core_stall, 0);
      step();
    end
    core_wr_en = 0;
    #1;
    chk("pri_acc_stall", core_stall, 0);
    step();
    chk("pri_dw_idx", rf_wrtInd, 7);
    chk("pri_dw_stall", core_stall, 1);
    acks = 0;
    repeat (4) begin
      step();
      acks += int'(dbg_ack);
    end
    chk("pri_single_ack", acks, 1);
    dbg_req = 0;
    step();
    chk("pri_mem10", mem[10], 32'h100);
    chk("pri_mem12", mem[12], 32'h102);
    chk("pri_mem7", mem[7], 32'h77);
    // reset during a debug read
    dbg_req = 1; dbg_we = 0; dbg_idx = 3;
    step();
    chk("rr_stall", core_stall, 1);
    chk("rr_rdidx", rf_rdInd1, 3);
    rst_n = 0;
    step();
    chk("rr_ack", dbg_ack, 0);
    chk("rr_wren", rf_wrtEn, 0);
    chk("rr_rdata", dbg_rdata, 0);
    chk("rr_done", init_done, 0);
    dbg_req = 0; rst_n = 1;
    #1;
    chk("rr_idx0", rf_wrtInd, 0);
    chk("rr_wren0", rf_wrtEn, 1);
    step();
    chk("rr_ack2", dbg_ack, 0);
    chk("rr_idx1", rf_wrtInd, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
